// File: rtl/bram_resp_pkg.sv
// Shared types and helpers for the windowed BRAM responder.
package bram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam int WIN_CNT_W = 16;

    // Even-parity bit: stored word plus this bit always has an even number of ones.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bram_window_responder_if.sv
// Controller <-> responder bus for the windowed BRAM access protocol.
interface bram_window_responder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    import bram_resp_pkg::*;

    // cs_rd/cs_wr are level-held windows with no back-pressure; rd_valid qualifies
    // rd_data for exactly the cycle it is high and is never stalled.
    logic                 cs_rd;
    logic                 cs_wr;
    logic [ADDR_W-1:0]    base_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 err;
    logic [WIN_CNT_W-1:0] win_cnt;
    state_t               state;

    modport master (
        output cs_rd, cs_wr, base_addr, wr_data,
        input  rd_data, rd_valid, busy, err, win_cnt, state
    );

    modport slave (
        input  cs_rd, cs_wr, base_addr, wr_data,
        output rd_data, rd_valid, busy, err, win_cnt, state
    );

endinterface

// File: rtl/bram_resp_array.sv
// Single-port synchronous RAM with registered read; one read or one write per cycle.
module bram_resp_array #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bram_window_responder.sv
// Memory-side responder servicing read/write chip-select windows as address bursts.
// Optional even-parity storage and checking under `BRAM_RESP_PARITY_EN.
module bram_window_responder
    import bram_resp_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input logic                    clk,
    input logic                    rst,
    bram_window_responder_if.slave bus
);

`ifdef BRAM_RESP_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t               state, next_state;
    logic [ADDR_W-1:0]    addr_ptr;
    logic [ADDR_W-1:0]    addr;
    logic                 rd_en, wr_en, done;
    logic                 rd_valid_q, err_q, par_err;
    logic [WIN_CNT_W-1:0] win_cnt_q;
    logic [MEM_W-1:0]     mem_wdata, mem_rdata;

    // addr_ptr always holds the address of the next beat in the current window.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        addr       = addr_ptr;
        case (state)
            IDLE: begin
                if (bus.cs_rd && bus.cs_wr) begin
                    next_state = ERR;
                end else if (bus.cs_rd) begin
                    next_state = RD;
                    rd_en      = 1'b1;
                    addr       = bus.base_addr;
                end else if (bus.cs_wr) begin
                    next_state = WR;
                    wr_en      = 1'b1;
                    addr       = bus.base_addr;
                end
            end
            RD: begin
                if (bus.cs_rd && bus.cs_wr) begin
                    next_state = ERR;
                end else if (!bus.cs_rd) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end else begin
                    rd_en = 1'b1;
                end
            end
            WR: begin
                if (bus.cs_rd && bus.cs_wr) begin
                    next_state = ERR;
                end else if (!bus.cs_wr) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
            end
            ERR: begin
                if (!bus.cs_rd && !bus.cs_wr) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_ptr   <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            win_cnt_q  <= '0;
        end else begin
            state      <= next_state;
            rd_valid_q <= rd_en;
            if (rd_en || wr_en) addr_ptr <= addr + 1'b1;
            if (next_state == ERR || par_err) err_q <= 1'b1;
            if (done) win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

`ifdef BRAM_RESP_PARITY_EN
    assign mem_wdata = {even_parity(64'(bus.wr_data)), bus.wr_data};
    assign par_err   = rd_valid_q &&
                       (mem_rdata[DATA_W] != even_parity(64'(mem_rdata[DATA_W-1:0])));
`else
    assign mem_wdata = bus.wr_data;
    assign par_err   = 1'b0;
`endif

    bram_resp_array #(
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .re    (rd_en),
        .addr  (addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // The RAM output register is not reset, so rd_data is held at zero outside valid beats.
    assign bus.rd_data  = rd_valid_q ? mem_rdata[DATA_W-1:0] : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state != IDLE);
    assign bus.err      = err_q || par_err;
    assign bus.win_cnt  = win_cnt_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_bram_window_responder.sv
// Directed self-checking bench for bram_window_responder (parity case under `BRAM_RESP_PARITY_EN).
module tb_bram_window_responder;
    import bram_resp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;

    logic [31:0] model_mem [16];
    logic [31:0] exp_q [$];

    bram_window_responder_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    bram_window_responder #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h expected=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_window(input logic [3:0] base, input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) begin
            bus.cs_wr     = 1'b1;
            bus.base_addr = base;
            bus.wr_data   = first + 32'(i);
            model_mem[base + 4'(i)] = first + 32'(i);
            step();
            chk("wr_busy", 32'(bus.busy), 32'd1);
        end
        bus.cs_wr = 1'b0;
        step();
        exp_cnt++;
        chk("wr_done_state", 32'(bus.state), 32'(IDLE));
    endtask

    task automatic rd_window(input logic [3:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[base + 4'(i)]);
        for (int i = 0; i < n; i++) begin
            bus.cs_rd     = 1'b1;
            bus.base_addr = base;
            step();
            chk("rd_valid", 32'(bus.rd_valid), 32'd1);
            chk("rd_data", bus.rd_data, exp_q.pop_front());
        end
        bus.cs_rd = 1'b0;
        step();
        exp_cnt++;
        chk("rd_valid_end", 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        bus.cs_rd     = 1'b0;
        bus.cs_wr     = 1'b0;
        bus.base_addr = '0;
        bus.wr_data   = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_win_cnt", 32'(bus.win_cnt), 32'd0);
        chk("rst_state", 32'(bus.state), 32'(IDLE));

        // Write then read back 11 words from base 3.
        wr_window(4'd3, 11, 32'hA0);
        rd_window(4'd3, 11);
        chk("t1_win_cnt", 32'(bus.win_cnt), 32'd2);
        chk("t1_err", 32'(bus.err), 32'd0);

        // Pointer wrap 14,15,0,1.
        wr_window(4'd14, 4, 32'hB0);
        rd_window(4'd0, 2);
        chk("t2_win_cnt", 32'(bus.win_cnt), 32'd4);

        // Read window ends on the same edge cs_wr rises; that first cs_wr cycle is not written.
        bus.cs_rd = 1'b1; bus.base_addr = 4'd5;
        step();
        chk("b2b_rd0", bus.rd_data, 32'hA2);
        step();
        chk("b2b_rd1", bus.rd_data, 32'hA3);
        bus.cs_rd = 1'b0; bus.cs_wr = 1'b1; bus.base_addr = 4'd8; bus.wr_data = 32'hC0;
        step();
        chk("b2b_idle", 32'(bus.state), 32'(IDLE));
        chk("b2b_valid", 32'(bus.rd_valid), 32'd0);
        bus.wr_data = 32'hC1;
        step();
        chk("b2b_wr", 32'(bus.state), 32'(WR));
        bus.wr_data = 32'hC2;
        step();
        bus.cs_wr = 1'b0;
        step();
        model_mem[8] = 32'hC1;
        model_mem[9] = 32'hC2;
        exp_cnt += 2;
        chk("b2b_win_cnt", 32'(bus.win_cnt), 32'(exp_cnt));
        rd_window(4'd8, 2);

        // Overlap: cs_wr rises on cycle 5 of a read window at base 3.
        for (int i = 0; i < 4; i++) begin
            bus.cs_rd = 1'b1; bus.base_addr = 4'd3;
            step();
            chk("ovl_rd", bus.rd_data, model_mem[4'd3 + 4'(i)]);
        end
        bus.cs_wr = 1'b1; bus.wr_data = 32'hDEAD;
        step();
        chk("ovl_state", 32'(bus.state), 32'(ERR));
        chk("ovl_err", 32'(bus.err), 32'd1);
        chk("ovl_valid", 32'(bus.rd_valid), 32'd0);
        chk("ovl_busy", 32'(bus.busy), 32'd1);
        chk("ovl_win_cnt", 32'(bus.win_cnt), 32'(exp_cnt));
        bus.cs_wr = 1'b0;
        step();
        chk("ovl_hold", 32'(bus.state), 32'(ERR));
        bus.cs_rd = 1'b0;
        step();
        chk("ovl_exit", 32'(bus.state), 32'(IDLE));
        chk("ovl_sticky", 32'(bus.err), 32'd1);
        rd_window(4'd7, 1);
        chk("ovl_cnt_after", 32'(bus.win_cnt), 32'(exp_cnt));

        // Reset on cycle 4 of a write window at base 10; that 4th word still commits.
        for (int i = 0; i < 4; i++) begin
            bus.cs_wr = 1'b1; bus.base_addr = 4'd10; bus.wr_data = 32'hE0 + 32'(i);
            model_mem[4'd10 + 4'(i)] = 32'hE0 + 32'(i);
            if (i == 3) rst = 1'b1;
            step();
        end
        chk("mrst_state", 32'(bus.state), 32'(IDLE));
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_err", 32'(bus.err), 32'd0);
        chk("mrst_valid", 32'(bus.rd_valid), 32'd0);
        chk("mrst_data", bus.rd_data, 32'd0);
        chk("mrst_win_cnt", 32'(bus.win_cnt), 32'd0);
        rst = 1'b0; bus.cs_wr = 1'b0;
        step();
        exp_cnt = 0;
        rd_window(4'd10, 5);
        chk("mrst_cnt_after", 32'(bus.win_cnt), 32'd1);

        // Counter wrap, preloaded close to the top.
        force dut.win_cnt_q = 16'hFFFE;
        step();
        release dut.win_cnt_q;
        step();
        chk("wrap_pre", 32'(bus.win_cnt), 32'hFFFE);
        rd_window(4'd3, 1);
        chk("wrap_ffff", 32'(bus.win_cnt), 32'hFFFF);
        rd_window(4'd3, 1);
        chk("wrap_zero", 32'(bus.win_cnt), 32'd0);
        chk("wrap_err", 32'(bus.err), 32'd0);

`ifdef BRAM_RESP_PARITY_EN
        wr_window(4'd7, 1, 32'h55);
        dut.u_array.mem[7][32] = ~dut.u_array.mem[7][32];
        bus.cs_rd = 1'b1; bus.base_addr = 4'd7;
        step();
        chk("par_valid", 32'(bus.rd_valid), 32'd1);
        chk("par_data", bus.rd_data, 32'h55);
        chk("par_err", 32'(bus.err), 32'd1);
        bus.cs_rd = 1'b0;
        step();
        chk("par_sticky", 32'(bus.err), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
